// File: rtl/apb_flash_bridge_v2.sv
// APB slave front end for the flash controller.
// Oversamples pclk on clk and turns APB transfers into flash requests.
`timescale 1ns/1ps
module apb_flash_bridge_v2 #(
    parameter int ADDR_W   = 32,
    parameter int FLASH_AW = 24,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 1023,
    parameter int EN_WRITE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pclk,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr,
    output logic                req_valid,
    output logic                req_write,
    output logic [FLASH_AW-1:0] req_addr,
    output logic [DATA_W-1:0]   req_wdata,
    output logic                req_abort,
    input  logic                rsp_done,
    input  logic [DATA_W-1:0]   rsp_rdata,
    input  logic                rsp_err,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_t;

    state_t              state_q;
    logic                pclk_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                req_valid_q;
    logic                req_write_q;
    logic                req_abort_q;
    logic                pslverr_q;
    logic [FLASH_AW-1:0] req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [DATA_W-1:0]   prdata_q;

    logic pneg;
    logic ppos;
    logic acc;
    logic addr_ok;
    logic wr_ill;
    logic bad;
    logic tmo;

    assign pneg    = pclk_q & ~pclk;
    assign ppos    = ~pclk_q & pclk;
    assign acc     = pneg & psel & penable & (state_q == IDLE);
    assign addr_ok = (paddr[ADDR_W-1:FLASH_AW] == '0);
    assign wr_ill  = pwrite & (EN_WRITE == 0);
    assign bad     = ~addr_ok | wr_ill;
    assign tmo     = (cnt_q == CNT_LAST);
    assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Previous pclk sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q <= 1'b0;
        end else begin
            pclk_q <= pclk;
        end
    end

    // Transfer FSM with registered request and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_abort_q <= 1'b0;
            pslverr_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            prdata_q    <= '0;
        end else begin
            req_valid_q <= 1'b0;
            req_abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (acc) begin
                        if (bad) begin
                            state_q   <= RESP;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                        end else begin
                            state_q     <= WAIT;
                            req_valid_q <= 1'b1;
                            req_write_q <= pwrite;
                            req_addr_q  <= paddr[FLASH_AW-1:0];
                            req_wdata_q <= pwdata;
                            cnt_q       <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (rsp_done) begin
                        state_q   <= RESP;
                        pslverr_q <= rsp_err;
                        if (!req_write_q) begin
                            prdata_q <= rsp_rdata;
                        end
                    end else if (tmo) begin
                        state_q     <= RESP;
                        req_abort_q <= 1'b1;
                        pslverr_q   <= 1'b1;
                        prdata_q    <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (ppos) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (pneg) begin
                        state_q   <= IDLE;
                        pslverr_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pready    = (state_q == RESP) | (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign prdata    = prdata_q;
    assign pslverr   = pslverr_q;
    assign req_valid = req_valid_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_abort = req_abort_q;

endmodule

// File: tb/tb_apb_flash_bridge_v2.sv
// Bench for apb_flash_bridge_v2: timeline model of APB transfers
// driven on two instances (writes enabled / writes disabled).
`timescale 1ns/1ps
module tb_apb_flash_bridge_v2;

    localparam int AW  = 32;
    localparam int FAW = 24;
    localparam int DW  = 32;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic pclk = 1'b0;
    logic psel [2];
    logic penable = 1'b0;
    logic pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic rsp_done = 1'b0;
    logic [DW-1:0] rsp_rdata = '0;
    logic rsp_err = 1'b0;

    logic pready_w [2];
    logic [DW-1:0] prdata_w [2];
    logic pslverr_w [2];
    logic req_valid_w [2];
    logic req_write_w [2];
    logic [FAW-1:0] req_addr_w [2];
    logic [DW-1:0] req_wdata_w [2];
    logic req_abort_w [2];
    logic busy_w [2];

    logic e_pready [2];
    logic [DW-1:0] e_prdata [2];
    logic e_pslverr [2];
    logic e_req_valid [2];
    logic e_req_write [2];
    logic [FAW-1:0] e_req_addr [2];
    logic [DW-1:0] e_req_wdata [2];
    logic e_req_abort [2];
    logic e_busy [2];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 0;

    int rv_cnt [2];
    int rv_cyc [2];
    int ab_cnt [2];
    int ab_cyc [2];
    int pr_cyc [2];
    logic prev_rdy [2];
    logic err_rdy [2];

    int hp_min = 4;
    int hp_max = 4;
    int pcnt = 4;
    logic pclk_prev = 1'b0;
    bit ppos_now = 0;
    bit pneg_now = 0;
    int late_at = -1;
    bit fix_en = 0;
    logic [DW-1:0] fix_rd = '0;
    logic fix_err = 1'b0;

    apb_flash_bridge_v2 #(
        .ADDR_W(AW), .FLASH_AW(FAW), .DATA_W(DW),
        .TIMEOUT(TO), .EN_WRITE(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pclk(pclk),
        .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_w[0]), .prdata(prdata_w[0]),
        .pslverr(pslverr_w[0]),
        .req_valid(req_valid_w[0]),
        .req_write(req_write_w[0]),
        .req_addr(req_addr_w[0]),
        .req_wdata(req_wdata_w[0]),
        .req_abort(req_abort_w[0]),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy_w[0])
    );

    apb_flash_bridge_v2 #(
        .ADDR_W(AW), .FLASH_AW(FAW), .DATA_W(DW),
        .TIMEOUT(TO), .EN_WRITE(0)
    ) u_dut_nw (
        .clk(clk), .rst_n(rst_n), .pclk(pclk),
        .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_w[1]), .prdata(prdata_w[1]),
        .pslverr(pslverr_w[1]),
        .req_valid(req_valid_w[1]),
        .req_write(req_write_w[1]),
        .req_addr(req_addr_w[1]),
        .req_wdata(req_wdata_w[1]),
        .req_abort(req_abort_w[1]),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h",
                     nm, i, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, plus event monitor.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("pready", i, 32'(pready_w[i]), 32'(e_pready[i]));
                chk("busy", i, 32'(busy_w[i]), 32'(e_busy[i]));
                chk("prdata", i, prdata_w[i], e_prdata[i]);
                chk("pslverr", i, 32'(pslverr_w[i]),
                    32'(e_pslverr[i]));
                chk("req_valid", i, 32'(req_valid_w[i]),
                    32'(e_req_valid[i]));
                chk("req_abort", i, 32'(req_abort_w[i]),
                    32'(e_req_abort[i]));
                chk("req_write", i, 32'(req_write_w[i]),
                    32'(e_req_write[i]));
                chk("req_addr", i, 32'(req_addr_w[i]),
                    32'(e_req_addr[i]));
                chk("req_wdata", i, req_wdata_w[i], e_req_wdata[i]);
                if (req_valid_w[i] === 1'b1) begin
                    rv_cnt[i]++;
                    rv_cyc[i] = cyc;
                end
                if (req_abort_w[i] === 1'b1) begin
                    ab_cnt[i]++;
                    ab_cyc[i] = cyc;
                end
                if (pready_w[i] === 1'b1) begin
                    err_rdy[i] = pslverr_w[i];
                    if (prev_rdy[i] !== 1'b1) pr_cyc[i] = cyc;
                end
                prev_rdy[i] = pready_w[i];
            end
        end
    end

    task automatic clear_exp();
        for (int i = 0; i < 2; i++) begin
            e_pready[i] = 0;
            e_prdata[i] = '0;
            e_pslverr[i] = 0;
            e_req_valid[i] = 0;
            e_req_write[i] = 0;
            e_req_addr[i] = '0;
            e_req_wdata[i] = '0;
            e_req_abort[i] = 0;
            e_busy[i] = 0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        e_req_valid[0] = 0;
        e_req_valid[1] = 0;
        e_req_abort[0] = 0;
        e_req_abort[1] = 0;
        pclk_prev = pclk;
        pcnt--;
        if (pcnt <= 0) begin
            pclk = ~pclk;
            pcnt = $urandom_range(hp_max, hp_min);
        end
        ppos_now = !pclk_prev && pclk;
        pneg_now = pclk_prev && !pclk;
        rsp_done = (cyc == late_at) || ($urandom_range(0, 5) == 0);
        rsp_rdata = $urandom;
        rsp_err = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        psel[0] = 0;
        psel[1] = 0;
        penable = 0;
        clear_exp();
        late_at = -1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
            chk("rst_pready", i, 32'(pready_w[i]), 32'd0);
            chk("rst_req_valid", i, 32'(req_valid_w[i]), 32'd0);
            chk("rst_prdata", i, prdata_w[i], 32'd0);
            chk("rst_req_addr", i, 32'(req_addr_w[i]), 32'd0);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // One complete APB transfer on instance i, with the flash
    // answering d cycles after the request (d >= TO never answers
    // in time). rst_j >= 0 resets the bridge in that WAIT cycle.
    task automatic xfer(input int i, input bit w,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int d, input int rst_j);
        bit bad;
        logic [31:0] rd;
        logic er;
        bad = (a[31:24] != 8'h0) || (w && i == 1);
        do next_cycle(); while (!ppos_now);
        psel[i] = 1;
        penable = 0;
        pwrite = w;
        paddr = a;
        pwdata = wd;
        do next_cycle(); while (!ppos_now);
        penable = 1;
        do next_cycle(); while (!pneg_now);
        next_cycle();
        if (bad) begin
            e_pready[i] = 1;
            e_busy[i] = 1;
            e_pslverr[i] = 1;
            e_prdata[i] = '0;
        end else begin
            e_busy[i] = 1;
            e_req_valid[i] = 1;
            e_req_write[i] = w;
            e_req_addr[i] = a[23:0];
            e_req_wdata[i] = wd;
            for (int j = 0; j < TO; j++) begin
                if (j == rst_j) begin
                    do_reset();
                    return;
                end
                rsp_done = (j == d);
                if (j == d) begin
                    if (fix_en) begin
                        rsp_rdata = fix_rd;
                        rsp_err = fix_err;
                    end
                    rd = rsp_rdata;
                    er = rsp_err;
                    next_cycle();
                    e_pready[i] = 1;
                    e_pslverr[i] = er;
                    if (!w) e_prdata[i] = rd;
                    break;
                end
                if (j == TO - 1) begin
                    late_at = cyc + (d - j);
                    next_cycle();
                    e_pready[i] = 1;
                    e_req_abort[i] = 1;
                    e_pslverr[i] = 1;
                    e_prdata[i] = '0;
                    break;
                end
                next_cycle();
            end
        end
        while (!ppos_now) next_cycle();
        next_cycle();
        psel[i] = 0;
        penable = 0;
        while (!pneg_now) next_cycle();
        next_cycle();
        e_pready[i] = 0;
        e_busy[i] = 0;
        e_pslverr[i] = 0;
        late_at = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=done", cyc);
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        int ab0;
        bit w;
        int i;
        logic [31:0] a;
        psel[0] = 0;
        psel[1] = 0;
        for (int k = 0; k < 2; k++) begin
            rv_cnt[k] = 0;
            rv_cyc[k] = 0;
            ab_cnt[k] = 0;
            ab_cyc[k] = 0;
            pr_cyc[k] = 0;
            prev_rdy[k] = 0;
            err_rdy[k] = 0;
        end
        clear_exp();
        #1;
        rst_n = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", k, 32'(busy_w[k]), 32'd0);
            chk("reset_pready", k, 32'(pready_w[k]), 32'd0);
            chk("reset_prdata", k, prdata_w[k], 32'd0);
        end
        rst_n = 1'b1;

        // Read with a 5-cycle flash response.
        fix_en = 1;
        fix_rd = 32'hDEADBEEF;
        fix_err = 1'b0;
        rv0 = rv_cnt[0];
        xfer(0, 0, 32'h0000_1234, 32'h0, 5, -1);
        chk("rd_prdata", 0, prdata_w[0], 32'hDEADBEEF);
        chk("rd_addr", 0, 32'(req_addr_w[0]), 32'h0000_1234);
        chk("rd_lat", 0, pr_cyc[0] - rv_cyc[0], 6);
        chk("rd_nreq", 0, rv_cnt[0] - rv0, 1);
        chk("rd_err", 0, 32'(err_rdy[0]), 32'd0);

        // Write answered with a flash error.
        fix_err = 1'b1;
        xfer(0, 1, 32'h0000_0010, 32'hA5A5A5A5, 3, -1);
        chk("wr_write", 0, 32'(req_write_w[0]), 32'd1);
        chk("wr_wdata", 0, req_wdata_w[0], 32'hA5A5A5A5);
        chk("wr_err", 0, 32'(err_rdy[0]), 32'd1);
        chk("wr_prdata", 0, prdata_w[0], 32'hDEADBEEF);

        // Out-of-range read, then write with writes disabled.
        rv0 = rv_cnt[0];
        xfer(0, 0, 32'h0100_0000, 32'h0, 2, -1);
        chk("oor_nreq", 0, rv_cnt[0] - rv0, 0);
        chk("oor_err", 0, 32'(err_rdy[0]), 32'd1);
        chk("oor_prdata", 0, prdata_w[0], 32'd0);
        xfer(1, 1, 32'h0000_0020, 32'h1111_2222, 2, -1);
        chk("nw_nreq", 1, rv_cnt[1], 0);
        chk("nw_err", 1, 32'(err_rdy[1]), 32'd1);
        chk("nw_prdata", 1, prdata_w[1], 32'd0);

        // Timeout with a late completion landing in RESP.
        fix_rd = 32'hCAFE_F00D;
        fix_err = 1'b0;
        ab0 = ab_cnt[0];
        xfer(0, 0, 32'h0000_0400, 32'h0, TO, -1);
        chk("to_nabort", 0, ab_cnt[0] - ab0, 1);
        chk("to_lat", 0, ab_cyc[0] - rv_cyc[0], 8);
        chk("to_prdata", 0, prdata_w[0], 32'd0);
        chk("to_err", 0, 32'(err_rdy[0]), 32'd1);

        // Completion exactly at the timeout threshold.
        fix_rd = 32'h1357_9BDF;
        ab0 = ab_cnt[0];
        xfer(0, 0, 32'h0000_0500, 32'h0, TO - 1, -1);
        chk("thr_nabort", 0, ab_cnt[0] - ab0, 0);
        chk("thr_prdata", 0, prdata_w[0], 32'h1357_9BDF);
        chk("thr_err", 0, 32'(err_rdy[0]), 32'd0);

        // Reset while waiting, then a clean read.
        xfer(0, 0, 32'h0000_0040, 32'h0, 5, 2);
        fix_rd = 32'h0BAD_CAFE;
        xfer(0, 0, 32'h0000_0044, 32'h0, 4, -1);
        chk("post_rst_prdata", 0, prdata_w[0], 32'h0BAD_CAFE);
        chk("post_rst_addr", 0, 32'(req_addr_w[0]), 32'h0000_0044);

        // Randomised traffic on both instances.
        fix_en = 0;
        hp_min = 1;
        hp_max = 6;
        for (int n = 0; n < 60; n++) begin
            i = ($urandom_range(0, 3) == 0) ? 1 : 0;
            w = 1'($urandom_range(0, 1));
            a = {8'h0, 24'($urandom)};
            if ($urandom_range(0, 5) == 0)
                a[31:24] = 8'($urandom_range(1, 255));
            xfer(i, w, a, $urandom, $urandom_range(0, 11), -1);
        end
        repeat (4) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_flash_bridge_v2.md
Name: apb_flash_bridge_v2

Overview:
Parametrised APB-slave front end for the flash controller, running on the fast controller clock `clk` and oversampling the slow APB clock `pclk` as a data input. It handles both APB reads and writes.
- Each valid transfer becomes a single-cycle request toward the flash engine.
- The bridge waits for completion, then drives `pready`, `prdata` and `pslverr` back on the APB side.
- It adds out-of-range and illegal-write error responses and a completion timeout with abort.

Parameters:
ADDR_W, 32, APB address width
FLASH_AW, 24, flash address width; ADDR_W > FLASH_AW
DATA_W, 32, data width of `pwdata`, `prdata`, `req_wdata` and `rsp_rdata`
TIMEOUT, 1023, clk cycles allowed in WAIT before abort; range 1..65535
EN_WRITE, 1, 1 = writes forwarded to flash; 0 = writes answered with `pslverr`

Ports:
clk  in  1  controller clock; all state is on its posedge
rst_n  in  1  asynchronous active-low reset
pclk  in  1  APB clock, sampled as data
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB direction, 1 = write
paddr  in  ADDR_W  APB address
pwdata  in  DATA_W  APB write data
pready  out  1  APB ready
prdata  out  DATA_W  APB read data
pslverr  out  1  APB error
req_valid  out  1  single-cycle flash request strobe
req_write  out  1  request direction, latched
req_addr  out  FLASH_AW  request address, latched
req_wdata  out  DATA_W  request write data, latched
req_abort  out  1  single-cycle strobe on timeout
rsp_done  in  1  flash completion strobe
rsp_rdata  in  DATA_W  flash read data, valid with `rsp_done`
rsp_err  in  1  flash error, valid with `rsp_done`
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs and internal registers are 0. The FSM is in IDLE. The registered copy `pclk_q` is 0.
- Edge detection: `pclk_q` is registered every clk.
  - pneg = pclk_q & ~pclk
  - ppos = ~pclk_q & pclk
- Access detect: `acc` = pneg & psel & penable & (state==IDLE). It is evaluated only in IDLE; APB activity in any other state is ignored.
- Address check: `addr_ok` = (paddr[ADDR_W-1:FLASH_AW] == 0).
- Illegal access: `bad` = ~addr_ok | (pwrite & ~EN_WRITE).
- FSM states: IDLE, WAIT, RESP, HOLD.
  - IDLE -> WAIT on acc & ~bad.
    - Same edge: `req_valid` = 1 for exactly the next cycle.
    - Latch `req_write` = pwrite, `req_addr` = paddr[FLASH_AW-1:0], `req_wdata` = pwdata.
    - Clear the timeout counter.
  - IDLE -> RESP on acc & bad.
    - No `req_valid`.
    - Set `pslverr` = 1; `prdata` is set to 0.
  - WAIT, on `rsp_done` -> RESP.
    - On a read, `prdata` <= rsp_rdata. On a write, `prdata` is unchanged.
    - `pslverr` <= rsp_err.
  - WAIT, no `rsp_done`: the counter increments. When counter == TIMEOUT-1 and there is no `rsp_done` -> RESP.
    - `req_abort` = 1 for one cycle.
    - `pslverr` = 1; `prdata` = 0.
  - WAIT, `rsp_done` and timeout in the same cycle: `rsp_done` wins and there is no abort.
  - RESP -> HOLD on ppos.
  - HOLD -> IDLE on pneg. On the same edge, clear `pslverr`. `prdata` holds its value.
- `pready` = 1 exactly in RESP and HOLD, decoded from state.
- `busy` = (state != IDLE).
- `rsp_done` outside WAIT is ignored: no state or data change.
- Counter width is ceil(log2(TIMEOUT+1)). It saturates and never wraps.
- `req_valid` and `req_abort` are never high in the same cycle.
- Latency: `req_valid` rises 1 clk after the sampling cycle of the pneg. `pready` rises 1 clk after the `rsp_done` cycle.
- `psel`/`penable` deasserting mid-transfer does not alter the FSM (protocol violation, no recovery required).
- Reset mid-transfer returns to IDLE with all outputs 0. No abort is issued.

Test Plan:
- Read paddr=0x0000_1234, flash returns rsp_rdata=0xDEADBEEF 5 clk after req_valid -> req_valid one cycle, req_addr=0x001234, req_write=0; prdata=0xDEADBEEF, pslverr=0; pready high from the cycle after rsp_done until the second following pclk negedge; busy drops with pready.
- Write paddr=0x0000_0010, pwdata=0xA5A5A5A5, EN_WRITE=1 -> req_write=1, req_wdata=0xA5A5A5A5; on rsp_done with rsp_err=1 -> pslverr=1 during pready.
- Out-of-range read paddr=0x0100_0000 -> no req_valid; pready=1, pslverr=1, prdata=0. Repeat as a write with EN_WRITE=0 at paddr=0x20 -> same error, no request.
- Timeout with TIMEOUT=8 and no rsp_done -> req_abort pulses exactly 8 clk after entry to WAIT; pslverr=1, prdata=0. A late rsp_done then arrives during RESP -> prdata stays 0.
- rsp_done in the same cycle as the timeout threshold -> no req_abort; prdata=rsp_rdata, pslverr=rsp_err.
- Assert rst_n=0 while in WAIT -> all outputs 0 immediately, state IDLE; the next read transfer completes normally.
